// File: rtl/disp_axi_rdarb.sv
// Two-port AR/R arbiter sharing one AXI read master: port 0 has fixed priority, port 1 gets starvation relief.
// ARVALID is registered one cycle after the pick; R routing is purely combinational by RID.
module disp_axi_rdarb #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_MAX_OUTS         = 4,
  parameter int C_STARVE_LIMIT     = 64
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S0_ARADDR,
  input  logic                          S0_ARVALID,
  output logic                          S0_ARREADY,
  output logic                          S0_RVALID,
  output logic                          S0_RLAST,
  input  logic                          S0_RREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S1_ARADDR,
  input  logic                          S1_ARVALID,
  output logic                          S1_ARREADY,
  output logic                          S1_RVALID,
  output logic                          S1_RLAST,
  input  logic                          S1_RREADY,
  output logic                          M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic                          M_AXI_RID,
  input  logic                          M_AXI_RVALID,
  input  logic                          M_AXI_RLAST,
  output logic                          M_AXI_RREADY,
  output logic [3:0]                    OUTS0,
  output logic [3:0]                    OUTS1,
  output logic                          RID_ERR
);

  localparam logic [3:0] MAX_OUTS     = 4'(C_MAX_OUTS);
  localparam logic [7:0] STARVE_LIMIT = 8'(C_STARVE_LIMIT);

  typedef enum logic {ST_IDLE, ST_ADDR} state_t;

  state_t                          state_q, state_d;
  logic                            arid_q, arid_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [3:0]                      outs0_q, outs0_d, outs1_q, outs1_d;
  logic [7:0]                      starve_q, starve_d;
  logic                            rid_err_q, rid_err_d;

  logic elig0, elig1, pick1;
  logic ar_hs, hs0, hs1;
  logic beat0, beat1, last0, last1;

  function automatic logic [3:0] outs_next(input logic [3:0] cur, input logic inc, input logic dec);
    if (inc && !dec)                   return cur + 4'd1;
    else if (dec && !inc && cur != '0) return cur - 4'd1;
    else                               return cur;
  endfunction

  always_comb begin
    elig0 = S0_ARVALID && (outs0_q < MAX_OUTS);
    elig1 = S1_ARVALID && (outs1_q < MAX_OUTS);
    pick1 = elig1 && ((starve_q >= STARVE_LIMIT) || !elig0);

    ar_hs = (state_q == ST_ADDR) && M_AXI_ARREADY;
    hs0   = ar_hs && !arid_q;
    hs1   = ar_hs && arid_q;

    beat0 = M_AXI_RVALID && M_AXI_RREADY && !M_AXI_RID;
    beat1 = M_AXI_RVALID && M_AXI_RREADY && M_AXI_RID;
    last0 = beat0 && M_AXI_RLAST;
    last1 = beat1 && M_AXI_RLAST;
  end

  always_comb begin
    state_d  = state_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    case (state_q)
      ST_IDLE: begin
        if (elig0 || elig1) begin
          state_d  = ST_ADDR;
          arid_d   = pick1;
          araddr_d = pick1 ? S1_ARADDR : S0_ARADDR;
        end
      end
      ST_ADDR: begin
        if (M_AXI_ARREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Starvation only accrues while port 1 could legally be granted; a full port just holds.
  always_comb begin
    starve_d = starve_q;
    if (!S1_ARVALID || hs1)                starve_d = '0;
    else if (elig1 && starve_q != 8'hFF)   starve_d = starve_q + 8'd1;
  end

  always_comb begin
    outs0_d   = outs_next(outs0_q, hs0, last0);
    outs1_d   = outs_next(outs1_q, hs1, last1);
    rid_err_d = rid_err_q
              | (beat0 && outs0_q == '0 && !hs0)
              | (beat1 && outs1_q == '0 && !hs1);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      arid_q    <= 1'b0;
      araddr_q  <= '0;
      outs0_q   <= '0;
      outs1_q   <= '0;
      starve_q  <= '0;
      rid_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      outs0_q   <= outs0_d;
      outs1_q   <= outs1_d;
      starve_q  <= starve_d;
      rid_err_q <= rid_err_d;
    end
  end

  assign M_AXI_ARVALID = (state_q == ST_ADDR);
  assign M_AXI_ARID    = arid_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign S0_ARREADY    = hs0;
  assign S1_ARREADY    = hs1;

  assign S0_RVALID     = M_AXI_RVALID && !M_AXI_RID;
  assign S1_RVALID     = M_AXI_RVALID &&  M_AXI_RID;
  assign S0_RLAST      = M_AXI_RLAST  && !M_AXI_RID;
  assign S1_RLAST      = M_AXI_RLAST  &&  M_AXI_RID;
  assign M_AXI_RREADY  = M_AXI_RID ? S1_RREADY : S0_RREADY;

  assign OUTS0   = outs0_q;
  assign OUTS1   = outs1_q;
  assign RID_ERR = rid_err_q;

endmodule

// File: tb/tb_disp_axi_rdarb.sv
// Directed bench for disp_axi_rdarb: reset, grant timing, starvation relief, outstanding limit, R routing, RID error.
module tb_disp_axi_rdarb;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] S0_ARADDR, S1_ARADDR;
  logic        S0_ARVALID, S1_ARVALID, S0_RREADY, S1_RREADY;
  logic        S0_ARREADY, S1_ARREADY, S0_RVALID, S1_RVALID, S0_RLAST, S1_RLAST;
  logic        M_AXI_ARID, M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_RID, M_AXI_RVALID, M_AXI_RLAST, M_AXI_RREADY;
  logic [3:0]  OUTS0, OUTS1;
  logic        RID_ERR;

  int tests = 0;
  int fails = 0;

  disp_axi_rdarb #(
    .C_M_AXI_ADDR_WIDTH(32), .C_MAX_OUTS(4), .C_STARVE_LIMIT(64)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S0_ARADDR(S0_ARADDR), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RVALID(S0_RVALID), .S0_RLAST(S0_RLAST), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RVALID(S1_RVALID), .S1_RLAST(S1_RLAST), .S1_RREADY(S1_RREADY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RID(M_AXI_RID), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RREADY(M_AXI_RREADY),
    .OUTS0(OUTS0), .OUTS1(OUTS1), .RID_ERR(RID_ERR)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic mid();
    @(negedge ACLK);
  endtask

  task automatic clear_inputs();
    S0_ARADDR = '0; S1_ARADDR = '0; S0_ARVALID = 0; S1_ARVALID = 0;
    S0_RREADY = 0; S1_RREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_RID = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ARESETN = 0;
    repeat (2) cyc();
    ARESETN = 1;
    cyc();
  endtask

  initial begin
    int n0, cyc1, after_id;
    logic seen1, seen_after;
    logic [31:0] addr1;

    // 1. reset values and idle behaviour, then async reset in ADDR
    do_reset();
    mid();
    chk("rst_arvalid", 32'(M_AXI_ARVALID), 0);
    chk("rst_arid",    32'(M_AXI_ARID), 0);
    chk("rst_araddr",  M_AXI_ARADDR, 0);
    chk("rst_rid_err", 32'(RID_ERR), 0);
    for (int i = 0; i < 100; i++) begin
      mid();
      chk("idle_arvalid", 32'(M_AXI_ARVALID), 0);
      chk("idle_outs0",   32'(OUTS0), 0);
      chk("idle_outs1",   32'(OUTS1), 0);
      cyc();
    end
    S0_ARVALID = 1; S0_ARADDR = 32'h0000_1234;
    cyc();
    mid();
    chk("addr_before_rst", 32'(M_AXI_ARVALID), 1);
    #1 ARESETN = 0;
    #1;
    chk("async_rst_arvalid", 32'(M_AXI_ARVALID), 0);
    chk("async_rst_araddr",  M_AXI_ARADDR, 0);

    // 2. single grant with ARREADY held low for 5 cycles
    do_reset();
    S0_ARVALID = 1; S0_ARADDR = 32'h0000_1000;
    mid();
    chk("t2_arvalid_c0", 32'(M_AXI_ARVALID), 0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("t2_arvalid_hold", 32'(M_AXI_ARVALID), 1);
      chk("t2_araddr_hold",  M_AXI_ARADDR, 32'h0000_1000);
      chk("t2_arid_hold",    32'(M_AXI_ARID), 0);
      chk("t2_s0_arready_lo", 32'(S0_ARREADY), 0);
      cyc();
    end
    M_AXI_ARREADY = 1;
    mid();
    chk("t2_s0_arready_pulse", 32'(S0_ARREADY), 1);
    chk("t2_s1_arready",       32'(S1_ARREADY), 0);
    cyc();
    S0_ARVALID = 0; M_AXI_ARREADY = 0;
    mid();
    chk("t2_s0_arready_end", 32'(S0_ARREADY), 0);
    chk("t2_arvalid_end",    32'(M_AXI_ARVALID), 0);
    chk("t2_outs0",          32'(OUTS0), 1);

    // 3. both ports request continuously; port 0 bursts are drained right after each grant
    do_reset();
    M_AXI_ARREADY = 1; S0_RREADY = 1;
    S0_ARVALID = 1; S0_ARADDR = 32'h0000_2000;
    S1_ARVALID = 1; S1_ARADDR = 32'h0000_3000;
    n0 = 0; cyc1 = -1; after_id = -1; seen1 = 0; seen_after = 0; addr1 = '0;
    for (int k = 0; k < 70; k++) begin
      M_AXI_RID = 0;
      M_AXI_RVALID = (OUTS0 != 0);
      M_AXI_RLAST  = (OUTS0 != 0);
      mid();
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        if (seen1 && !seen_after) begin
          seen_after = 1;
          after_id = int'(M_AXI_ARID);
        end else if (!seen1 && M_AXI_ARID) begin
          seen1 = 1; cyc1 = k; addr1 = M_AXI_ARADDR;
        end else if (!seen1) begin
          n0++;
        end
      end
      cyc();
    end
    clear_inputs();
    chk("t3_port0_grants", 32'(n0), 32);
    chk("t3_port1_cycle",  32'(cyc1), 65);
    chk("t3_port1_addr",   addr1, 32'h0000_3000);
    chk("t3_next_id",      32'(after_id), 0);
    chk("t3_outs1",        32'(OUTS1), 1);
    chk("t3_rid_err",      32'(RID_ERR), 0);

    // 4. outstanding limit on port 0
    do_reset();
    M_AXI_ARREADY = 1;
    S0_ARVALID = 1; S0_ARADDR = 32'h0000_4000;
    repeat (8) begin mid(); cyc(); end
    S1_ARVALID = 1; S1_ARADDR = 32'h0000_5000;
    mid();
    chk("t4_outs0_full",   32'(OUTS0), 4);
    chk("t4_arvalid_c8",   32'(M_AXI_ARVALID), 0);
    cyc();
    mid();
    chk("t4_p1_arvalid",   32'(M_AXI_ARVALID), 1);
    chk("t4_p1_arid",      32'(M_AXI_ARID), 1);
    chk("t4_s1_arready",   32'(S1_ARREADY), 1);
    chk("t4_s0_arready",   32'(S0_ARREADY), 0);
    cyc();
    S1_ARVALID = 0;
    mid();
    chk("t4_outs1",        32'(OUTS1), 1);
    cyc();
    M_AXI_RVALID = 1; M_AXI_RLAST = 1; M_AXI_RID = 0; S0_RREADY = 1;
    mid();
    chk("t4_blocked",      32'(M_AXI_ARVALID), 0);
    chk("t4_s0_rvalid",    32'(S0_RVALID), 1);
    chk("t4_s0_rlast",     32'(S0_RLAST), 1);
    chk("t4_s1_rvalid",    32'(S1_RVALID), 0);
    chk("t4_rready",       32'(M_AXI_RREADY), 1);
    cyc();
    M_AXI_RVALID = 0; M_AXI_RLAST = 0;
    mid();
    chk("t4_outs0_dec",    32'(OUTS0), 3);
    cyc();
    mid();
    chk("t4_p0_arid",      32'(M_AXI_ARID), 0);
    chk("t4_p0_arready",   32'(S0_ARREADY), 1);
    chk("t4_p0_araddr",    M_AXI_ARADDR, 32'h0000_4000);
    cyc();
    S0_ARVALID = 0;
    mid();
    chk("t4_outs0_refill", 32'(OUTS0), 4);
    cyc();

    // 5. interleaved R beats, then AR handshake coinciding with RLAST on port 0
    M_AXI_RVALID = 1; M_AXI_RLAST = 0; M_AXI_RID = 0; S0_RREADY = 1; S1_RREADY = 0;
    mid();
    chk("t5_a_s0_rvalid", 32'(S0_RVALID), 1);
    chk("t5_a_s1_rvalid", 32'(S1_RVALID), 0);
    chk("t5_a_rready",    32'(M_AXI_RREADY), 1);
    cyc();
    M_AXI_RID = 1;
    mid();
    chk("t5_b_s1_rvalid", 32'(S1_RVALID), 1);
    chk("t5_b_s0_rvalid", 32'(S0_RVALID), 0);
    chk("t5_b_rready",    32'(M_AXI_RREADY), 0);
    cyc();
    M_AXI_RID = 0; M_AXI_RLAST = 1;
    mid();
    chk("t5_c_rready",    32'(M_AXI_RREADY), 1);
    chk("t5_c_s0_rlast",  32'(S0_RLAST), 1);
    cyc();
    M_AXI_RVALID = 0; M_AXI_RLAST = 0;
    S0_ARVALID = 1; S0_ARADDR = 32'h0000_6000;
    mid();
    chk("t5_d_outs0",     32'(OUTS0), 3);
    chk("t5_d_outs1",     32'(OUTS1), 1);
    cyc();
    M_AXI_RVALID = 1; M_AXI_RLAST = 1; M_AXI_RID = 0;
    mid();
    chk("t5_e_s0_arready", 32'(S0_ARREADY), 1);
    chk("t5_e_rready",     32'(M_AXI_RREADY), 1);
    cyc();
    clear_inputs();
    mid();
    chk("t5_f_outs0_same", 32'(OUTS0), 3);
    chk("t5_f_rid_err",    32'(RID_ERR), 0);
    cyc();

    // 6. RLAST for a port with nothing outstanding
    do_reset();
    M_AXI_RVALID = 1; M_AXI_RLAST = 1; M_AXI_RID = 1; S1_RREADY = 1;
    mid();
    chk("t6_s1_rvalid",  32'(S1_RVALID), 1);
    cyc();
    clear_inputs();
    mid();
    chk("t6_rid_err",    32'(RID_ERR), 1);
    chk("t6_outs1",      32'(OUTS1), 0);
    repeat (3) begin
      cyc();
      mid();
      chk("t6_rid_err_sticky", 32'(RID_ERR), 1);
    end
    #1 ARESETN = 0;
    #1;
    chk("t6_rid_err_rst", 32'(RID_ERR), 0);
    #1 ARESETN = 1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
